// File: rtl/alarm_bank.sv
// Multi-channel HH:MM alarm unit for the 24-hour BCD clock.
// Fires on the exact minute boundary and runs a ring / snooze / timeout sequence.
module alarm_bank #(
    parameter int NUM_CH     = 4,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60,
    parameter int MAX_SNOOZE = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_1s,
    input  logic [3:0]        cur_h10,
    input  logic [3:0]        cur_h1,
    input  logic [3:0]        cur_m10,
    input  logic [3:0]        cur_m1,
    input  logic [3:0]        cur_s10,
    input  logic [3:0]        cur_s1,
    input  logic              wr_en,
    input  logic [2:0]        wr_ch,
    input  logic [15:0]       wr_time,
    input  logic              tog_en,
    input  logic              snooze,
    input  logic              stop,
    output logic              ring,
    output logic [2:0]        ring_ch,
    output logic              snoozing,
    output logic [NUM_CH-1:0] armed,
    output logic [1:0]        snz_cnt
);

    localparam logic [7:0] RING_LOAD   = 8'(RING_SEC);
    localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_MIN * 60);
    localparam logic [1:0] SNOOZE_LIM  = 2'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RING,
        ST_SNOOZE
    } state_t;

    state_t      state;
    logic [15:0] alarm_time [NUM_CH];
    logic [7:0]  ring_ctr;
    logic [9:0]  snz_ctr;

    logic [NUM_CH-1:0] match;
    logic              hit_any;
    logic [2:0]        hit_idx;
    logic [15:0]       cur_hm;
    logic              sec_zero;
    logic              abort;

    assign cur_hm   = {cur_h10, cur_h1, cur_m10, cur_m1};
    assign sec_zero = tick_1s && (cur_s10 == 4'd0) && (cur_s1 == 4'd0);

    // A single tick at ss=00 means each channel can match only once per minute.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            match[c] = sec_zero && armed[c] && (cur_hm == alarm_time[c]);
        end
    end

    // Lowest-index channel wins when several match on the same tick.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = 3'd0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (match[c]) begin
                hit_any = 1'b1;
                hit_idx = 3'(c);
            end
        end
    end

    // Any write or toggle aimed at the active channel cancels the current firing.
    assign abort = (wr_en || tog_en) && (wr_ch == ring_ch);

    // Out-of-range channel numbers never compare equal to a loop index, so they are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            armed <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                alarm_time[c] <= 16'h0000;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_en && (wr_ch == 3'(c))) begin
                    alarm_time[c] <= wr_time;
                end
                if (tog_en && (wr_ch == 3'(c))) begin
                    armed[c] <= ~armed[c];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            ring     <= 1'b0;
            ring_ch  <= 3'd0;
            snoozing <= 1'b0;
            snz_cnt  <= 2'd0;
            ring_ctr <= 8'd0;
            snz_ctr  <= 10'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ring     <= 1'b0;
                    snoozing <= 1'b0;
                    snz_cnt  <= 2'd0;
                    if (hit_any) begin
                        state    <= ST_RING;
                        ring     <= 1'b1;
                        ring_ch  <= hit_idx;
                        ring_ctr <= RING_LOAD;
                    end
                end

                // Keys take priority over a coincident tick; the counter holds.
                ST_RING: begin
                    if (abort || stop || (snooze && (snz_cnt == SNOOZE_LIM))) begin
                        state    <= ST_IDLE;
                        ring     <= 1'b0;
                        snoozing <= 1'b0;
                        snz_cnt  <= 2'd0;
                    end else if (snooze) begin
                        state    <= ST_SNOOZE;
                        ring     <= 1'b0;
                        snoozing <= 1'b1;
                        snz_cnt  <= snz_cnt + 2'd1;
                        snz_ctr  <= SNOOZE_LOAD;
                    end else if (tick_1s) begin
                        ring_ctr <= ring_ctr - 8'd1;
                        if (ring_ctr == 8'd1) begin
                            state    <= ST_IDLE;
                            ring     <= 1'b0;
                            snoozing <= 1'b0;
                            snz_cnt  <= 2'd0;
                        end
                    end
                end

                ST_SNOOZE: begin
                    if (abort || stop) begin
                        state    <= ST_IDLE;
                        ring     <= 1'b0;
                        snoozing <= 1'b0;
                        snz_cnt  <= 2'd0;
                    end else if (tick_1s) begin
                        snz_ctr <= snz_ctr - 10'd1;
                        if (snz_ctr == 10'd1) begin
                            state    <= ST_RING;
                            ring     <= 1'b1;
                            snoozing <= 1'b0;
                            ring_ctr <= RING_LOAD;
                        end
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    ring     <= 1'b0;
                    snoozing <= 1'b0;
                    snz_cnt  <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_bank.sv
// Directed self-checking bench for alarm_bank: firing, priority, timeout,
// snooze sequencing, abort paths, ignored channels and mid-ring reset.
module tb_alarm_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick_1s;
    logic [3:0]  cur_h10, cur_h1, cur_m10, cur_m1, cur_s10, cur_s1;
    logic        wr_en;
    logic [2:0]  wr_ch;
    logic [15:0] wr_time;
    logic        tog_en;
    logic        snooze;
    logic        stop;
    logic        ring;
    logic [2:0]  ring_ch;
    logic        snoozing;
    logic [3:0]  armed;
    logic [1:0]  snz_cnt;

    int checks = 0;
    int errors = 0;

    alarm_bank #(
        .NUM_CH(4), .SNOOZE_MIN(5), .RING_SEC(60), .MAX_SNOOZE(3)
    ) dut (
        .clk(clk), .reset(reset), .tick_1s(tick_1s),
        .cur_h10(cur_h10), .cur_h1(cur_h1), .cur_m10(cur_m10),
        .cur_m1(cur_m1), .cur_s10(cur_s10), .cur_s1(cur_s1),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_time(wr_time), .tog_en(tog_en),
        .snooze(snooze), .stop(stop),
        .ring(ring), .ring_ch(ring_ch), .snoozing(snoozing),
        .armed(armed), .snz_cnt(snz_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setTime(input logic [3:0] h10, h1, m10, m1, s10, s1);
        cur_h10 = h10; cur_h1 = h1; cur_m10 = m10;
        cur_m1 = m1; cur_s10 = s10; cur_s1 = s1;
    endtask

    task automatic applyStimulus(input logic t, input logic sn, input logic st);
        tick_1s = t; snooze = sn; stop = st;
        step();
        tick_1s = 1'b0; snooze = 1'b0; stop = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    endtask

    task automatic writeAlarm(input logic [2:0] ch, input logic [15:0] t);
        wr_ch = ch; wr_time = t; wr_en = 1'b1;
        step();
        wr_en = 1'b0;
    endtask

    task automatic toggleArm(input logic [2:0] ch);
        wr_ch = ch; tog_en = 1'b1;
        step();
        tog_en = 1'b0;
    endtask

    // Fire channel 3 (alarm 08:00) and leave the clock at 08:00:01.
    task automatic fireCh3();
        setTime(4'd0, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        setTime(4'd0, 4'd8, 4'd0, 4'd0, 4'd0, 4'd1);
    endtask

    initial begin
        reset = 1'b1; tick_1s = 1'b0; wr_en = 1'b0; wr_ch = 3'd0;
        wr_time = 16'h0; tog_en = 1'b0; snooze = 1'b0; stop = 1'b0;
        setTime(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        step(); step();
        reset = 1'b0;
        checkOutput("rst_ring", 32'(ring), 32'd0);
        checkOutput("rst_ring_ch", 32'(ring_ch), 32'd0);
        checkOutput("rst_snoozing", 32'(snoozing), 32'd0);
        checkOutput("rst_armed", 32'(armed), 32'd0);
        checkOutput("rst_snz_cnt", 32'(snz_cnt), 32'd0);

        // Basic fire on channel 1 at 07:30
        writeAlarm(3'd1, 16'h0730);
        toggleArm(3'd1);
        checkOutput("arm_ch1", 32'(armed), 32'h2);
        setTime(4'd0, 4'd7, 4'd2, 4'd9, 4'd5, 4'd9);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("pre_match_ring", 32'(ring), 32'd0);
        setTime(4'd0, 4'd7, 4'd3, 4'd0, 4'd0, 4'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("match_ring", 32'(ring), 32'd1);
        checkOutput("match_ring_ch", 32'(ring_ch), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("stop_ring", 32'(ring), 32'd0);
        toggleArm(3'd1);

        // Two channels matching together: lowest index wins, no retrigger later
        writeAlarm(3'd0, 16'h0600);
        writeAlarm(3'd2, 16'h0600);
        toggleArm(3'd0);
        toggleArm(3'd2);
        checkOutput("arm_ch0_ch2", 32'(armed), 32'h5);
        setTime(4'd0, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("prio_ring", 32'(ring), 32'd1);
        checkOutput("prio_ring_ch", 32'(ring_ch), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("prio_stop", 32'(ring), 32'd0);
        setTime(4'd0, 4'd6, 4'd0, 4'd0, 4'd3, 4'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        setTime(4'd0, 4'd6, 4'd0, 4'd1, 4'd0, 4'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("no_retrigger", 32'(ring), 32'd0);
        checkOutput("ring_ch_holds", 32'(ring_ch), 32'd0);
        toggleArm(3'd0);
        toggleArm(3'd2);

        // Auto timeout after 60 ticks on channel 3
        writeAlarm(3'd3, 16'h0800);
        toggleArm(3'd3);
        checkOutput("arm_ch3", 32'(armed), 32'h8);
        fireCh3();
        checkOutput("ch3_ring", 32'(ring), 32'd1);
        checkOutput("ch3_ring_ch", 32'(ring_ch), 32'd3);
        ticks(59);
        checkOutput("timeout_59", 32'(ring), 32'd1);
        ticks(1);
        checkOutput("timeout_60", 32'(ring), 32'd0);
        checkOutput("timeout_snz_cnt", 32'(snz_cnt), 32'd0);
        checkOutput("timeout_snoozing", 32'(snoozing), 32'd0);

        // Snooze three times (first press coincides with a tick), fourth acts as stop
        fireCh3();
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(k == 1, 1'b1, 1'b0);
            checkOutput("snz_ring_low", 32'(ring), 32'd0);
            checkOutput("snz_active", 32'(snoozing), 32'd1);
            checkOutput("snz_count", 32'(snz_cnt), 32'(k));
            ticks(299);
            checkOutput("snz_299", 32'(snoozing), 32'd1);
            ticks(1);
            checkOutput("snz_rering", 32'(ring), 32'd1);
            checkOutput("snz_rering_ch", 32'(ring_ch), 32'd3);
            checkOutput("snz_rering_flag", 32'(snoozing), 32'd0);
        end
        checkOutput("snz_cnt_max", 32'(snz_cnt), 32'd3);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("snz4_ring", 32'(ring), 32'd0);
        checkOutput("snz4_snoozing", 32'(snoozing), 32'd0);
        checkOutput("snz4_snz_cnt", 32'(snz_cnt), 32'd0);

        // Toggle off the active channel while snoozing aborts
        fireCh3();
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("abort_pre", 32'(snoozing), 32'd1);
        toggleArm(3'd3);
        checkOutput("abort_snoozing", 32'(snoozing), 32'd0);
        checkOutput("abort_armed", 32'(armed), 32'h0);
        checkOutput("abort_snz_cnt", 32'(snz_cnt), 32'd0);

        // STOP and SNOOZE together while ringing: stop wins
        toggleArm(3'd3);
        fireCh3();
        checkOutput("both_pre", 32'(ring), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("both_ring", 32'(ring), 32'd0);
        checkOutput("both_snoozing", 32'(snoozing), 32'd0);

        // Writing the active channel while ringing aborts but keeps it armed
        fireCh3();
        writeAlarm(3'd3, 16'h0800);
        checkOutput("write_abort", 32'(ring), 32'd0);
        checkOutput("write_keeps_arm", 32'(armed), 32'h8);

        // Out-of-range channel is ignored; then reset mid-ring
        fireCh3();
        wr_ch = 3'd7; wr_time = 16'h1234; wr_en = 1'b1; tog_en = 1'b1;
        step();
        wr_en = 1'b0; tog_en = 1'b0;
        checkOutput("ch7_armed", 32'(armed), 32'h8);
        checkOutput("ch7_ring", 32'(ring), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("midrst_ring", 32'(ring), 32'd0);
        checkOutput("midrst_ring_ch", 32'(ring_ch), 32'd0);
        checkOutput("midrst_armed", 32'(armed), 32'd0);
        checkOutput("midrst_snoozing", 32'(snoozing), 32'd0);
        checkOutput("midrst_snz_cnt", 32'(snz_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
